// File: rtl/multi_key_decoder.sv
// multi_key_decoder: tracks NUM_KEYS PS/2 keys.
// Each key has a held level, press and release strobes, and a frame-paced auto-repeat strobe.
// Every output is registered. A make or breakk in cycle N is visible in cycle N+1.
module multi_key_decoder #(
  parameter int                    NUM_KEYS     = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_VALUES   = {9'h072, 9'h075, 9'h074, 9'h06B},
  parameter int                    REPEAT_DELAY = 30,
  parameter int                    REPEAT_RATE  = 6,
  parameter int                    CNT_W        = 8
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [8:0]          key_code,
  input  logic                make,
  input  logic                breakk,
  input  logic                startOfFrame,
  output logic [NUM_KEYS-1:0] keyIsPressed,
  output logic [NUM_KEYS-1:0] keyPressPulse,
  output logic [NUM_KEYS-1:0] keyReleasePulse,
  output logic [NUM_KEYS-1:0] keyRepeatPulse,
  output logic                anyKeyPressed,
  output logic [3:0]          lastKeyIdx
);

  localparam logic [CNT_W-1:0] LP_DELAY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] LP_RATE   = CNT_W'(REPEAT_RATE);
  localparam bit               LP_REP_EN = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  logic [NUM_KEYS-1:0] r_held;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] r_release;
  logic [NUM_KEYS-1:0] r_rep;
  logic                r_any;
  logic [3:0]          r_last;
  state_t              r_state [NUM_KEYS];
  logic [CNT_W-1:0]    r_cnt   [NUM_KEYS];

  logic [NUM_KEYS-1:0] w_hit;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic [NUM_KEYS-1:0] w_held_nxt;
  logic [3:0]          w_last_nxt;
  logic [CNT_W-1:0]    w_cnt_inc [NUM_KEYS];

  // Match the code against every slot.
  // When make and breakk arrive together, the cycle counts as a break only.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_hit[i] = (make | breakk) && (key_code == KEY_VALUES[9*i +: 9]);
    end
    w_press    = w_hit & {NUM_KEYS{make & ~breakk}} & ~r_held;
    w_release  = w_hit & {NUM_KEYS{breakk}} & r_held;
    w_held_nxt = (r_held | w_press) & ~w_release;
  end

  // Choose the lowest newly pressed index. Otherwise hold the previous index.
  always_comb begin
    w_last_nxt = r_last;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (w_press[i]) w_last_nxt = 4'(i);
    end
  end

  // Next value of each frame counter.
  // Compare-and-clear keeps the counter below its target, so the increment cannot wrap.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_cnt_inc[i] = r_cnt[i] + CNT_W'(1);
    end
  end

  // Register the held levels, the edge strobes, the any-key flag and the last index.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_held    <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_any     <= 1'b0;
      r_last    <= 4'd0;
    end else begin
      r_held    <= w_held_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      r_any     <= |w_held_nxt;
      r_last    <= w_last_nxt;
    end
  end

  // Per-key repeat FSM.
  // A press or release overrides a startOfFrame in the same cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rep <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_rep[i] <= 1'b0;
        if (w_release[i]) begin
          r_state[i] <= S_IDLE;
          r_cnt[i]   <= '0;
        end else if (w_press[i]) begin
          r_cnt[i]   <= '0;
          r_state[i] <= LP_REP_EN ? S_DELAY : S_IDLE;
        end else if (startOfFrame) begin
          case (r_state[i])
            S_DELAY: begin
              if (w_cnt_inc[i] == LP_DELAY) begin
                r_rep[i]   <= 1'b1;
                r_cnt[i]   <= '0;
                r_state[i] <= S_REPEAT;
              end else begin
                r_cnt[i] <= w_cnt_inc[i];
              end
            end
            S_REPEAT: begin
              if (w_cnt_inc[i] == LP_RATE) begin
                r_rep[i] <= 1'b1;
                r_cnt[i] <= '0;
              end else begin
                r_cnt[i] <= w_cnt_inc[i];
              end
            end
            default: begin
              r_state[i] <= S_IDLE;
              r_cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign keyIsPressed    = r_held;
  assign keyPressPulse   = r_press;
  assign keyReleasePulse = r_release;
  assign keyRepeatPulse  = r_rep;
  assign anyKeyPressed   = r_any;
  assign lastKeyIdx      = r_last;

endmodule

// File: tb/tb_multi_key_decoder.sv
// Directed bench for multi_key_decoder.
// Runs the default build and a build with REPEAT_DELAY=0.
module tb_multi_key_decoder;

  logic       clk = 1'b0;
  logic       resetN;
  logic [8:0] key_code;
  logic       make, breakk, startOfFrame;

  logic [3:0] d_held, d_press, d_rel, d_rep, d_last;
  logic       d_any;
  logic [3:0] z_held, z_press, z_rel, z_rep, z_last;
  logic       z_any;

  int errors = 0;
  int checks = 0;
  int zrep_seen;

  always #5 clk = ~clk;

  multi_key_decoder dut (
    .clk(clk), .resetN(resetN), .key_code(key_code), .make(make), .breakk(breakk),
    .startOfFrame(startOfFrame), .keyIsPressed(d_held), .keyPressPulse(d_press),
    .keyReleasePulse(d_rel), .keyRepeatPulse(d_rep), .anyKeyPressed(d_any),
    .lastKeyIdx(d_last)
  );

  multi_key_decoder #(.REPEAT_DELAY(0)) dut_norep (
    .clk(clk), .resetN(resetN), .key_code(key_code), .make(make), .breakk(breakk),
    .startOfFrame(startOfFrame), .keyIsPressed(z_held), .keyPressPulse(z_press),
    .keyReleasePulse(z_rel), .keyRepeatPulse(z_rep), .anyKeyPressed(z_any),
    .lastKeyIdx(z_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of strobes, then sample just after the edge that registers them.
  task automatic step(input logic m, input logic b, input logic [8:0] code, input logic sof);
    make = m; breakk = b; key_code = code; startOfFrame = sof;
    @(posedge clk); #1;
    make = 1'b0; breakk = 1'b0; startOfFrame = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    resetN = 1'b0; make = 1'b0; breakk = 1'b0; startOfFrame = 1'b0; key_code = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", d_held, 4'b0000);
    chk("reset_pulses", {d_press, d_rel, d_rep}, 12'h000);
    chk("reset_any_last", {d_any, d_last}, 5'h00);
    resetN = 1'b1;
    tick();

    // 1: a single press and release of 06B
    step(1'b1, 1'b0, 9'h06B, 1'b0);
    chk("t1_held", d_held, 4'b0001);
    chk("t1_press", d_press, 4'b0001);
    chk("t1_last", d_last, 4'd0);
    chk("t1_any", d_any, 1'b1);
    tick();
    chk("t1_press_1cyc", d_press, 4'b0000);
    chk("t1_held_stays", d_held, 4'b0001);
    step(1'b0, 1'b1, 9'h06B, 1'b0);
    chk("t1_rel", d_rel, 4'b0001);
    chk("t1_held_off", {d_any, d_held}, 5'h00);
    tick();
    chk("t1_rel_1cyc", d_rel, 4'b0000);

    // 2: hold 074 for 36 frames with typematic re-makes
    step(1'b1, 1'b0, 9'h074, 1'b0);
    chk("t2_press", d_press, 4'b0010);
    chk("t2_last", d_last, 4'd1);
    for (int f = 1; f <= 36; f++) begin
      step(1'b0, 1'b0, 9'h000, 1'b1);
      chk($sformatf("t2_rep_f%0d", f), d_rep, (f == 30 || f == 36) ? 4'b0010 : 4'b0000);
      if (f % 5 == 0) begin
        step(1'b1, 1'b0, 9'h074, 1'b0);
        chk($sformatf("t2_typematic_f%0d", f), {d_press, d_held}, {4'b0000, 4'b0010});
      end
    end
    // frames 37..41; the release lands on frame 42 together with startOfFrame
    for (int f = 37; f <= 41; f++) begin
      step(1'b0, 1'b0, 9'h000, 1'b1);
      chk($sformatf("t2_rep_f%0d", f), d_rep, 4'b0000);
    end
    step(1'b0, 1'b1, 9'h074, 1'b1);
    chk("t2_relsof_rep", d_rep, 4'b0000);
    chk("t2_relsof_rel", d_rel, 4'b0010);
    // a press together with startOfFrame: that frame is not counted
    step(1'b1, 1'b0, 9'h074, 1'b1);
    chk("t2_presssof", d_press, 4'b0010);
    for (int f = 1; f <= 30; f++) begin
      step(1'b0, 1'b0, 9'h000, 1'b1);
      chk($sformatf("t2b_rep_f%0d", f), d_rep, (f == 30) ? 4'b0010 : 4'b0000);
    end
    step(1'b0, 1'b1, 9'h074, 1'b0);
    chk("t2_cleanup", d_held, 4'b0000);

    // 3: overlapping presses
    step(1'b1, 1'b0, 9'h06B, 1'b0);
    chk("t3_held_a", {d_held, d_last}, {4'b0001, 4'd0});
    step(1'b1, 1'b0, 9'h074, 1'b0);
    chk("t3_held_b", {d_held, d_last}, {4'b0011, 4'd1});
    step(1'b0, 1'b1, 9'h06B, 1'b0);
    chk("t3_held_c", {d_held, d_last}, {4'b0010, 4'd1});
    chk("t3_rel", d_rel, 4'b0001);
    tick();
    chk("t3_rel_once", d_rel, 4'b0000);
    step(1'b0, 1'b1, 9'h074, 1'b0);
    chk("t3_cleanup", {d_any, d_held}, 5'h00);

    // 4: make and breakk together; breakk of an unheld key
    step(1'b1, 1'b1, 9'h075, 1'b0);
    chk("t4_mb_held", d_held, 4'b0000);
    chk("t4_mb_pulses", {d_press, d_rel}, 8'h00);
    step(1'b0, 1'b1, 9'h072, 1'b0);
    chk("t4_unheld_brk", {d_rel, d_held, d_any}, 9'h000);
    chk("t4_last_hold", d_last, 4'd1);

    // 5: untracked code, then the build with repeat disabled
    step(1'b1, 1'b0, 9'h0E1, 1'b0);
    chk("t5_untracked", {d_held, d_press, d_rel, d_any, d_last}, {4'b0, 4'b0, 4'b0, 1'b0, 4'd1});
    step(1'b1, 1'b0, 9'h06B, 1'b0);
    chk("t5_z_press", {z_held, z_press}, {4'b0001, 4'b0001});
    zrep_seen = 0;
    for (int f = 1; f <= 100; f++) begin
      step(1'b0, 1'b0, 9'h000, 1'b1);
      if (z_rep != 4'b0000) zrep_seen++;
    end
    chk("t5_z_norep", zrep_seen, 0);
    chk("t5_z_held", z_held, 4'b0001);
    step(1'b0, 1'b1, 9'h06B, 1'b0);
    chk("t5_cleanup", {d_held, z_held}, 8'h00);

    // 6: reset while a key is held
    step(1'b1, 1'b0, 9'h06B, 1'b0);
    for (int f = 1; f <= 20; f++) step(1'b0, 1'b0, 9'h000, 1'b1);
    chk("t6_held_pre", d_held, 4'b0001);
    #2 resetN = 1'b0;
    #1;
    chk("t6_async_clear", {d_held, d_press, d_rel, d_rep, d_any, d_last}, 21'h0);
    @(negedge clk);
    resetN = 1'b1;
    tick();
    tick();
    chk("t6_no_rel", {d_rel, d_held}, 8'h00);
    step(1'b1, 1'b0, 9'h06B, 1'b0);
    chk("t6_rearm", d_press, 4'b0001);
    for (int f = 1; f <= 30; f++) begin
      step(1'b0, 1'b0, 9'h000, 1'b1);
      if (f >= 29) chk($sformatf("t6_rep_f%0d", f), d_rep, (f == 30) ? 4'b0001 : 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
